// File: rtl/parity_rx.sv
// rtl/parity_rx.sv - serial start/data/parity/stop frame receiver with parity and framing checks
module parity_rx #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_ODD   = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sin,
   output logic [DATA_W-1:0] dout,
   output logic              valid,
   output logic              parity_err,
   output logic              frame_err,
   output logic              busy
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
   localparam logic             ODD      = (PARITY_ODD != 0);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;

   state_t            state;
   logic              sin_m;
   logic              sin_s;
   logic [CNT_W-1:0]  cnt;
   logic [IDX_W-1:0]  bit_idx;
   logic [DATA_W-1:0] shift;
   logic              acc;
   logic              perr;
   logic              half_hit;
   logic              bit_hit;

   assign half_hit = (cnt == HALF_END);
   assign bit_hit  = (cnt == BIT_END);

   // Line idles high, so the synchroniser resets to 1 to avoid a false start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sin_m <= 1'b1;
         sin_s <= 1'b1;
      end else begin
         sin_m <= sin;
         sin_s <= sin_m;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         shift      <= '0;
         acc        <= 1'b0;
         perr       <= 1'b0;
         dout       <= '0;
         valid      <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         valid <= 1'b0;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (!sin_s) begin
                  state <= START;
                  busy  <= 1'b1;
               end
            end
            // Half-bit wait puts every later sample at a bit centre.
            START: begin
               if (half_hit) begin
                  cnt <= '0;
                  if (!sin_s) begin
                     state   <= DATA;
                     bit_idx <= '0;
                     acc     <= 1'b0;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (bit_hit) begin
                  cnt            <= '0;
                  shift[bit_idx] <= sin_s;
                  acc            <= acc ^ sin_s;
                  if (bit_idx == LAST_IDX) begin
                     state <= PARITY;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            PARITY: begin
               if (bit_hit) begin
                  cnt   <= '0;
                  perr  <= ((acc ^ sin_s) != ODD);
                  state <= STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            STOP: begin
               if (bit_hit) begin
                  cnt        <= '0;
                  dout       <= shift;
                  parity_err <= perr;
                  frame_err  <= ~sin_s;
                  valid      <= 1'b1;
                  if (sin_s) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state <= BRK;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            // A held-low line must go high before another start is accepted.
            BRK: begin
               cnt <= '0;
               if (sin_s) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_parity_rx.sv
// tb/tb_parity_rx.sv - scoreboard bench for parity_rx with directed frames
module tb_parity_rx;

   localparam int CPB = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sin = 1'b1;
   logic [7:0] dout;
   logic       valid;
   logic       parity_err;
   logic       frame_err;
   logic       busy;

   typedef struct packed {
      logic [7:0] d;
      logic       pe;
      logic       fe;
   } exp_t;

   exp_t sb[$];
   exp_t e_mon;
   int   total = 0;
   int   bad = 0;
   int   valid_cnt = 0;
   logic prev_valid = 1'b0;

   parity_rx #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_ODD(0)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sin        (sin),
      .dout       (dout),
      .valid      (valid),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic expect_frame(input logic [7:0] d, input logic pe, input logic fe);
      exp_t e;
      e.d  = d;
      e.pe = pe;
      e.fe = fe;
      sb.push_back(e);
   endtask

   task automatic drive_bit(input logic b);
      sin = b;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic p, input logic stop);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      drive_bit(p);
      drive_bit(stop);
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 100; i++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
      end
      @(negedge clk);
      chk({name, "_drain"}, sb.size(), 0);
   endtask

   task automatic chk_reset_outputs(input string name);
      chk({name, "_dout"}, dout, 0);
      chk({name, "_valid"}, valid, 0);
      chk({name, "_perr"}, parity_err, 0);
      chk({name, "_ferr"}, frame_err, 0);
      chk({name, "_busy"}, busy, 0);
   endtask

   always @(negedge clk) begin
      if (rst_n && valid) begin
         valid_cnt++;
         chk("valid_one_cycle", prev_valid, 0);
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_valid: got dout=%0h want no valid", dout);
         end else begin
            e_mon = sb.pop_front();
            chk("dout", dout, e_mon.d);
            chk("parity_err", parity_err, e_mon.pe);
            chk("frame_err", frame_err, e_mon.fe);
         end
      end
      prev_valid <= rst_n & valid;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      int   vc;
      logic seen;

      rst_n = 1'b0;
      sin   = 1'b1;
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // 1: 0xA5 has four ones, even parity bit 0 is correct
      expect_frame(8'hA5, 1'b0, 1'b0);
      send_frame(8'hA5, 1'b0, 1'b1);
      sin = 1'b1;
      wait_drain("t1");
      chk("t1_busy", busy, 0);
      repeat (4) @(negedge clk);

      // 2: wrong parity bit
      expect_frame(8'hA5, 1'b1, 1'b0);
      send_frame(8'hA5, 1'b1, 1'b1);
      sin = 1'b1;
      wait_drain("t2");
      chk("t2_busy", busy, 0);
      repeat (4) @(negedge clk);

      // 3: stop bit low, line held low
      expect_frame(8'h3C, 1'b0, 1'b1);
      send_frame(8'h3C, 1'b0, 1'b0);
      repeat (20) @(negedge clk);
      chk("t3_valid_seen", sb.size(), 0);
      chk("t3_busy_held", busy, 1);
      sin = 1'b1;
      repeat (6) @(negedge clk);
      chk("t3_busy_released", busy, 0);
      repeat (4) @(negedge clk);

      // 4: one-clock glitch
      vc   = valid_cnt;
      seen = 1'b0;
      sin  = 1'b0;
      @(negedge clk);
      sin = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (busy) seen = 1'b1;
      end
      chk("t4_busy_pulse", seen, 1);
      chk("t4_busy_idle", busy, 0);
      chk("t4_no_valid", valid_cnt, vc);
      repeat (4) @(negedge clk);

      // 5: back-to-back frames
      expect_frame(8'h01, 1'b0, 1'b0);
      expect_frame(8'hFF, 1'b0, 1'b0);
      send_frame(8'h01, 1'b1, 1'b1);
      send_frame(8'hFF, 1'b0, 1'b1);
      sin = 1'b1;
      wait_drain("t5");
      chk("t5_busy", busy, 0);
      repeat (4) @(negedge clk);

      // 6: reset during data bit 4 of 0x55
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(i[0] ? 1'b0 : 1'b1);
      sin = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("t6_rst_async");
      repeat (3) @(negedge clk);
      chk_reset_outputs("t6_rst_held");
      sin = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      expect_frame(8'h0F, 1'b0, 1'b0);
      send_frame(8'h0F, 1'b0, 1'b1);
      sin = 1'b1;
      wait_drain("t6");
      chk("t6_busy", busy, 0);

      repeat (10) @(negedge clk);
      chk("valid_count", valid_cnt, 6);
      chk("sb_empty", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
